// File: rtl/axis_window_3x3.sv
// axis_window_3x3: streaming 3x3 neighbourhood generator.
// Keeps the two previous image lines in line buffers and a 3x3 register
// window, and emits one window per interior output position (no padding).
// Single registered output stage; input ready is combinational from it.
module axis_window_3x3 #(
  parameter int DATA_WIDTH = 24,
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tuser,
  output logic [9*DATA_WIDTH-1:0] m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tuser,
  output logic                    err_sof,
  output logic                    err_eol
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0] col, col_nxt, eff_col;
  logic [RW-1:0] row, row_nxt, eff_row;
  logic          accept, at_end, gen, sof_hit, eol_hit;

  logic [DATA_WIDTH-1:0] lb_old [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb_new [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] win [3][3];

  assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;

  // Position of the current beat (tuser forces (0,0)), checks and next position
  always_comb begin
    eff_col = s_axis_tuser ? '0 : col;
    eff_row = s_axis_tuser ? '0 : row;
    sof_hit = s_axis_tuser && ((col != '0) || (row != '0));
    at_end  = (eff_col == COL_LAST);
    eol_hit = (s_axis_tlast != at_end);
    gen     = (eff_row >= ROW_TWO) && (eff_col >= COL_TWO);
    col_nxt = eff_col + CW'(1);
    row_nxt = eff_row;
    // an early tlast ends the line as well: realign to the next row
    if (at_end || s_axis_tlast) begin
      col_nxt = '0;
      row_nxt = (eff_row == ROW_LAST) ? '0 : eff_row + RW'(1);
    end
  end

  // Position counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      col <= col_nxt;
      row <= row_nxt;
    end
  end

  // Line buffers; unreset because validity gating rewrites them before use
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_old[eff_col] <= lb_new[eff_col];
      lb_new[eff_col] <= s_axis_tdata;
    end
  end

  // Window shifts left; new right column is {row-2, row-1, current pixel}
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= '0;
    end else if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= lb_old[eff_col];
      win[1][2] <= lb_new[eff_col];
      win[2][2] <= s_axis_tdata;
    end
  end

  // Output stage: load on generating accept, otherwise drain on handshake
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      err_sof       <= 1'b0;
      err_eol       <= 1'b0;
    end else begin
      err_sof <= accept && sof_hit;
      err_eol <= accept && eol_hit;
      if (accept && gen) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= at_end;
        m_axis_tuser  <= (eff_row == ROW_TWO) && (eff_col == COL_TWO);
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

  // Window only moves on accept, which implies the held window was consumed
  always_comb begin
    m_axis_tdata = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        m_axis_tdata[(3*r+c)*DATA_WIDTH +: DATA_WIDTH] = win[r][c];
  end

endmodule

// File: tb/tb_axis_window_3x3.sv
// Testbench for axis_window_3x3 on a 4x4 image with 8-bit pixels.
module tb_axis_window_3x3;

  localparam int DW = 8;
  localparam int TW = 9 * DW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser;
  logic [TW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
  logic          err_sof, err_eol;

  axis_window_3x3 #(.DATA_WIDTH(DW), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser),
    .err_sof(err_sof), .err_eol(err_eol)
  );

  always #5 clk = ~clk;

  // base: -1 no window expected, -2 window expected but data not checked,
  // otherwise the top-left pixel value of the expected window
  typedef struct {
    int pix;
    bit tu;
    bit tl;
    int base;
    bit elast;
    bit euser;
    bit esof;
    bit eeol;
  } beat_t;

  beat_t tbl [128];
  int    n = 0;
  int    checks = 0;
  int    errors = 0;

  task automatic add(int pix, bit tu, bit tl, int base, bit el, bit eu, bit es, bit ee);
    tbl[n] = '{pix, tu, tl, base, el, eu, es, ee};
    n++;
  endtask

  // A clean beat of a 4x4 frame whose pixel at (r,c) is off + r*4 + c
  task automatic add_std(int off, int r, int c, bit es);
    int base;
    base = (r >= 2 && c >= 2) ? off + (r-2)*4 + (c-2) : -1;
    add(off + r*4 + c, (r == 0 && c == 0), (c == 3), base, (c == 3), (r == 2 && c == 2), es, 1'b0);
  endtask

  function automatic logic [TW-1:0] win_of(int b);
    logic [TW-1:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[(3*r+c)*DW +: DW] = DW'(b + r*4 + c);
    return w;
  endfunction

  task automatic chk(string nm, int idx, logic [TW-1:0] act, logic [TW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s idx %0d actual %0h required %0h", nm, idx, act, exp);
    end
  endtask

  // Apply table entries lo..hi, one beat per cycle, checking the cycle after
  task automatic run_seg(int lo, int hi);
    for (int i = lo; i <= hi; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = DW'(tbl[i].pix);
      s_axis_tuser  = tbl[i].tu;
      s_axis_tlast  = tbl[i].tl;
      @(posedge clk);
      #1;
      chk("s_tready", i, TW'(s_axis_tready), TW'(1));
      chk("m_valid", i, TW'(m_axis_tvalid), TW'(tbl[i].base != -1));
      if (tbl[i].base != -1) begin
        chk("m_last", i, TW'(m_axis_tlast), TW'(tbl[i].elast));
        chk("m_user", i, TW'(m_axis_tuser), TW'(tbl[i].euser));
      end
      if (tbl[i].base >= 0)
        chk("m_data", i, m_axis_tdata, win_of(tbl[i].base));
      chk("err_sof", i, TW'(err_sof), TW'(tbl[i].esof));
      chk("err_eol", i, TW'(err_eol), TW'(tbl[i].eeol));
    end
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic chk_reset_vals(int tag);
    chk("rst_tready", tag, TW'(s_axis_tready), TW'(1));
    chk("rst_valid", tag, TW'(m_axis_tvalid), TW'(0));
    chk("rst_data", tag, m_axis_tdata, '0);
    chk("rst_last", tag, TW'(m_axis_tlast), TW'(0));
    chk("rst_user", tag, TW'(m_axis_tuser), TW'(0));
    chk("rst_err_sof", tag, TW'(err_sof), TW'(0));
    chk("rst_err_eol", tag, TW'(err_eol), TW'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Segment 0..31: two back-to-back clean frames (offsets 0 and 32)
    for (int k = 0; k < 16; k++) add_std(0, k/4, k%4, 1'b0);
    for (int k = 0; k < 16; k++) add_std(32, k/4, k%4, 1'b0);
    // Segment 32..56: tuser arrives at (2,1) of a frame, new frame follows
    for (int k = 0; k < 9; k++) add_std(64, k/4, k%4, 1'b0);
    for (int k = 0; k < 16; k++) add_std(100, k/4, k%4, (k == 0));
    // Segment 57..71: early tlast at (1,2); column 3 of row 1 is never written
    for (int c = 0; c < 4; c++) add_std(200, 0, c, 1'b0);
    add_std(200, 1, 0, 1'b0);
    add_std(200, 1, 1, 1'b0);
    add(206, 1'b0, 1'b1, -1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int r = 2; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (c == 3) add(200 + r*4 + c, 1'b0, 1'b1, -2, 1'b1, 1'b0, 1'b0, 1'b0);
        else        add_std(200, r, c, 1'b0);

    reset_n       = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    m_axis_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals(0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    run_seg(0, 31);
    run_seg(32, 56);
    run_seg(57, 71);

    // Output stall at the first window
    run_seg(0, 10);
    m_axis_tready = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = DW'(tbl[11].pix);
    s_axis_tlast  = tbl[11].tl;
    s_axis_tuser  = tbl[11].tu;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("stall_valid", k, TW'(m_axis_tvalid), TW'(1));
      chk("stall_data", k, m_axis_tdata, win_of(0));
      chk("stall_user", k, TW'(m_axis_tuser), TW'(1));
      chk("stall_tready", k, TW'(s_axis_tready), TW'(0));
    end
    m_axis_tready = 1'b1;
    run_seg(11, 15);

    // Reset mid-frame at (3,1), then a fresh clean frame
    run_seg(0, 12);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = DW'(13);
    reset_n       = 1'b0;
    #1;
    chk_reset_vals(1);
    s_axis_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_valid", 0, TW'(m_axis_tvalid), TW'(0));
    run_seg(0, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
